fetch_stage: RTL

//  RV32I instruction-fetch stage. Owns the PC and issues in-order requests to instruction memory.

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared RV32I fetch definitions: default widths and reset PC, the canonical
// NOP encoding shown to decode when nothing is buffered, and opcode/field
// types that decode uses when it slices opcode/funct3 out of if_instr.
package fetch_stage_pkg;

  localparam int unsigned DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_IMM = 7'b0010011,
    OP_REG = 7'b0110011
  } opcode_e;

  // R-type field view of an instruction word; decode overlays it on if_instr.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32_instr_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer for the fetch stage.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data this cycle (ignored during flush)
//   push_data   - {instr, pc} entry
//   pop         - drop the head entry (ignored when empty or during flush)
//   flush       - discard every entry; wins over push and pop
//   count       - number of valid entries, 0..DEPTH
//   head        - oldest entry; contents undefined when count == 0
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    push_en  = push && !flush;
    pop_en   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      wr_ptr_d = wr_ptr_q + AW'(push_en);
      rd_ptr_d = rd_ptr_q + AW'(pop_en);
      count_d  = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone decides
  // what is valid, and leaving the array reset-free lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // The fetch credit rule must keep pushes from ever landing on a full buffer.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    push_en |-> ((count_q != CW'(DEPTH)) || pop_en));

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage.
// Owns the fetch PC, issues in-order word requests to instruction memory,
// buffers the returned words with their PCs and hands {instr, pc} to decode
// over a valid/ready pair. A redirect flushes the buffer and arranges for
// every response still in flight to be discarded on arrival.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       - request channel (addr is the fetch PC)
//   imem_rsp_valid/data             - in-order responses, no backpressure
//   redirect_valid/pc               - restart fetch at redirect_pc & ~3
//   if_valid/ready/instr/pc         - instruction handoff to decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN            = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEF_RESET_PC),
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int unsigned ENTRY_W = 32 + XLEN;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  // Wide enough to hold outstanding + count without overflow.
  localparam int unsigned SUM_W   = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic [OUT_W-1:0]   drop_q, drop_d;

  logic               fifo_push, fifo_pop, fifo_flush;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [SUM_W-1:0]   credit_used;
  logic [XLEN-1:0]    redirect_pc_aligned;
  logic               req_fire;

  assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

  // Issue depends only on registered state (plus the redirect veto): a pop in
  // this cycle does not free a slot until the next one. Reserving a buffer
  // slot per in-flight request is what guarantees a push always fits.
  assign credit_used    = SUM_W'(outstanding_q) + SUM_W'(fifo_count);
  assign imem_req_valid = rst_n && !redirect_valid
                          && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                          && (credit_used < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid   = (fifo_count != '0);
  assign if_instr   = if_valid ? fifo_head[ENTRY_W-1:XLEN] : NOP_INSTR;
  assign if_pc      = if_valid ? fifo_head[XLEN-1:0] : '0;

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    fifo_pop      = if_valid && if_ready && !redirect_valid;

    if (redirect_valid) begin
      // No request can fire this cycle, so only an arriving response changes
      // the in-flight count; it is discarded here, and every request still in
      // flight afterwards must be discarded on arrival. This recomputation
      // also absorbs any drop count left over from an earlier redirect.
      pc_d          = redirect_pc_aligned;
      rsp_pc_d      = redirect_pc_aligned;
      fifo_flush    = 1'b1;
      outstanding_d = outstanding_q - OUT_W'(imem_rsp_valid);
      drop_d        = outstanding_q - OUT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OUT_W'(1);
        end else begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + XLEN'(4);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({imem_rsp_data, rsp_pc_q}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Memory may only answer requests it has accepted.
  a_rsp_has_request : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0));

endmodule
